// File: rtl/uart_rx_multi.sv
// uart_rx_multi: oversampling UART receiver with optional parity, one or two stop bits, break
// detection and an AXI-Stream output buffer.
// Build option: define UART_RX_MULTI_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise the
// output buffer is a single register.
module uart_rx_multi #(
   parameter int unsigned CLOCK      = 100_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic [1:0]           m_axis_tuser,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 overrun,
   output logic                 break_det
);
   localparam int unsigned COUNT_SPEED = CLOCK / BAUD_RATE;
   localparam int unsigned CW = (COUNT_SPEED > 1) ? $clog2(COUNT_SPEED) : 1;
   localparam logic [CW-1:0] CNT_S0   = CW'(COUNT_SPEED / 2 - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(COUNT_SPEED / 2);
   localparam logic [CW-1:0] CNT_S2   = CW'(COUNT_SPEED / 2 + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_SPEED - 1);
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic STOP_LAST = (STOP_BITS == 2);
   localparam int unsigned UW = DATA_BITS + 2;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreakWait} state_e;

   logic                 rx_meta_q, rx_sync_q;
   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        bit_q;
   logic                 stop_q;
   logic [1:0]           samp_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 perr_q, pbit_q, ferr_q, stop_hi_q;

   logic          resolve, maj, par_exp, last_stop, frame_break, push;
   logic [UW-1:0] push_word;

   // Two-flop synchroniser; resets high so reset release never looks like a start bit.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Majority vote of the three mid-bit samples and frame completion decode.
   always_comb begin
      resolve     = (cnt_q == CNT_S2);
      maj         = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync_q) | (samp_q[0] & rx_sync_q);
      par_exp     = (PARITY == 2) ? ~^shift_q : ^shift_q;
      last_stop   = (state_q == StStop) && (stop_q == STOP_LAST);
      frame_break = (shift_q == '0) && !pbit_q && !stop_hi_q && !maj;
      push        = last_stop && resolve && !frame_break;
      push_word   = {perr_q, ferr_q | ~maj, shift_q};
   end

   // Receive FSM: bit timing, data capture, parity/stop checks and break detection.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         stop_q    <= 1'b0;
         samp_q    <= '0;
         shift_q   <= '0;
         perr_q    <= 1'b0;
         pbit_q    <= 1'b0;
         ferr_q    <= 1'b0;
         stop_hi_q <= 1'b0;
         break_det <= 1'b0;
      end else begin
         break_det <= 1'b0;
         if (state_q != StIdle && state_q != StBreakWait) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0 || cnt_q == CNT_S1) begin
               samp_q <= {samp_q[0], rx_sync_q};
            end
         end
         unique case (state_q)
            StIdle: begin
               if (!rx_sync_q) begin
                  state_q   <= StStart;
                  cnt_q     <= '0;
                  bit_q     <= '0;
                  stop_q    <= 1'b0;
                  perr_q    <= 1'b0;
                  pbit_q    <= 1'b0;
                  ferr_q    <= 1'b0;
                  stop_hi_q <= 1'b0;
               end
            end
            StStart: begin
               if (resolve && maj) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= StData;
               end
            end
            StData: begin
               if (resolve) begin
                  shift_q <= {maj, shift_q[DATA_BITS-1:1]};
               end
               if (cnt_q == CNT_LAST) begin
                  if (bit_q == BIT_LAST) begin
                     state_q <= (PARITY != 0) ? StParity : StStop;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end
            StParity: begin
               if (resolve) begin
                  pbit_q <= maj;
                  perr_q <= (maj != par_exp);
               end
               if (cnt_q == CNT_LAST) begin
                  state_q <= StStop;
               end
            end
            StStop: begin
               if (resolve) begin
                  if (!maj) ferr_q <= 1'b1;
                  else      stop_hi_q <= 1'b1;
                  // Leave mid-bit so a start bit right after a short stop is caught.
                  if (last_stop) begin
                     cnt_q <= '0;
                     if (frame_break) begin
                        break_det <= 1'b1;
                        state_q   <= StBreakWait;
                     end else begin
                        state_q <= StIdle;
                     end
                  end
               end else if (cnt_q == CNT_LAST) begin
                  stop_q <= 1'b1;
               end
            end
            StBreakWait: begin
               if (rx_sync_q) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef UART_RX_MULTI_FIFO_EN
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [UW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          pop, full, wr_en;

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_comb begin
      pop   = (count_q != '0) && m_axis_tready;
      full  = (count_q == (AW + 1)'(FIFO_DEPTH));
      wr_en = push && (!full || pop);
   end

   // FIFO storage, pointers, occupancy and overrun pulse.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         overrun  <= 1'b0;
      end else begin
         overrun <= push && full && !pop;
         if (wr_en) begin
            mem_q[wr_ptr_q] <= push_word;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_en && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !wr_en) count_q <= count_q - 1'b1;
      end
   end

   assign m_axis_tvalid                = (count_q != '0);
   assign {m_axis_tuser, m_axis_tdata} = mem_q[rd_ptr_q];
`else
   logic [UW-1:0] word_q;
   logic          valid_q, pop;
   logic          unused_fifo_depth;

   assign pop               = valid_q && m_axis_tready;
   assign unused_fifo_depth = ^FIFO_DEPTH;

   // Single-entry output register; a push into an occupied, unpopped slot is dropped.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= push && valid_q && !pop;
         if (push && (!valid_q || pop)) begin
            word_q  <= push_word;
            valid_q <= 1'b1;
         end else if (pop) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign m_axis_tvalid                = valid_q;
   assign {m_axis_tuser, m_axis_tdata} = word_q;
`endif

endmodule

// File: tb/tb_uart_rx_multi.sv
// Directed bench for uart_rx_multi at 32 clocks per bit (8N1 and 8E1 instances).
module tb_uart_rx_multi;
   localparam int BIT = 32;

   logic       aclk = 1'b0;
   logic       areset = 1'b1;
   logic       rx = 1'b1;
   logic       tready = 1'b1;
   logic [7:0] tdata;
   logic [1:0] tuser;
   logic       tvalid, ovr, brk;

   logic       par_rx = 1'b1;
   logic [7:0] par_tdata;
   logic [1:0] par_tuser;
   logic       par_tvalid, par_ovr, par_brk;

   int checks = 0;
   int errors = 0;
   int brk_cnt = 0;
   int ovr_cnt = 0;
   logic [9:0] beats[$];
   logic [9:0] par_beats[$];

   always #5 aclk = ~aclk;

   uart_rx_multi #(
      .CLOCK(100_000_000), .BAUD_RATE(3_125_000), .DATA_BITS(8), .PARITY(0),
      .STOP_BITS(1), .FIFO_DEPTH(16)
   ) dut (
      .aclk(aclk), .areset(areset), .uart_rx(rx), .m_axis_tdata(tdata),
      .m_axis_tuser(tuser), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .overrun(ovr), .break_det(brk)
   );

   uart_rx_multi #(
      .CLOCK(100_000_000), .BAUD_RATE(3_125_000), .DATA_BITS(8), .PARITY(1),
      .STOP_BITS(1), .FIFO_DEPTH(16)
   ) dut_par (
      .aclk(aclk), .areset(areset), .uart_rx(par_rx), .m_axis_tdata(par_tdata),
      .m_axis_tuser(par_tuser), .m_axis_tvalid(par_tvalid), .m_axis_tready(1'b1),
      .overrun(par_ovr), .break_det(par_brk)
   );

   // Observe transfers and pulses away from the active edge.
   always @(negedge aclk) begin
      if (tvalid && tready) beats.push_back({tuser, tdata});
      if (par_tvalid) par_beats.push_back({par_tuser, par_tdata});
      if (brk) brk_cnt++;
      if (ovr) ovr_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic line_bit(input bit sel, input logic v);
      if (sel) par_rx = v;
      else     rx = v;
      tick(BIT);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                             input logic pbit, input logic stop, input int gap_bits);
      line_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) line_bit(sel, d[i]);
      if (has_par) line_bit(sel, pbit);
      line_bit(sel, stop);
      if (sel) par_rx = 1'b1;
      else     rx = 1'b1;
      tick(gap_bits * BIT);
   endtask

   task automatic expect_one(input string name, input logic [9:0] exp);
      checks++;
      if (beats.size() != 1) begin
         errors++;
         $display("FAIL %s: beat count %0d, expected 1", name, beats.size());
      end else if (beats[0] !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, beats[0], exp);
      end
      beats.delete();
   endtask

   task automatic test_reset;
      tick(3);
      checks++;
      if ({tvalid, tdata, tuser, ovr, brk} !== 13'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, expected 0", {tvalid, tdata, tuser, ovr, brk});
      end
      checks++;
      if ({par_tvalid, par_tdata, par_tuser} !== 11'h0) begin
         errors++;
         $display("FAIL reset_par_outputs: got %b, expected 0", {par_tvalid, par_tdata, par_tuser});
      end
      areset = 1'b0;
      tick(2 * BIT);
   endtask

   task automatic test_basic;
      beats.delete();
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 2);
      expect_one("frame_a5", {2'b00, 8'hA5});
      send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2);
      expect_one("frame_00", {2'b00, 8'h00});
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 2);
      expect_one("frame_ff", {2'b00, 8'hFF});
   endtask

   task automatic test_parity;
      logic [9:0] exp[3];
      exp[0] = {2'b10, 8'h03};
      exp[1] = {2'b00, 8'h03};
      exp[2] = {2'b00, 8'h07};
      par_beats.delete();
      send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 2);
      send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 2);
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 2);
      checks++;
      if (par_beats.size() != 3) begin
         errors++;
         $display("FAIL parity_count: got %0d, expected 3", par_beats.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (par_beats[i] !== exp[i]) begin
               errors++;
               $display("FAIL parity_%0d: got %h, expected %h", i, par_beats[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_framing;
      int b0;
      b0 = brk_cnt;
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 3);
      expect_one("framing_55", {2'b01, 8'h55});
      checks++;
      if (brk_cnt != b0) begin
         errors++;
         $display("FAIL framing_no_break: got %0d pulses, expected 0", brk_cnt - b0);
      end
   endtask

   task automatic test_glitch;
      beats.delete();
      rx = 1'b0;
      tick(10);
      rx = 1'b1;
      tick(3 * BIT);
      checks++;
      if (beats.size() != 0 || tvalid !== 1'b0) begin
         errors++;
         $display("FAIL glitch_no_output: got %0d beats, expected 0", beats.size());
      end
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 2);
      expect_one("after_glitch_3c", {2'b00, 8'h3C});
   endtask

   task automatic test_back_to_back;
      beats.delete();
      send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 0);
      send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1, 2);
      checks++;
      if (beats.size() != 2 || beats[0] !== 10'h012 || beats[1] !== 10'h034) begin
         errors++;
         $display("FAIL back_to_back: got %0d beats, expected 012 then 034", beats.size());
      end
      beats.delete();
   endtask

   task automatic test_break;
      int b0;
      beats.delete();
      b0 = brk_cnt;
      rx = 1'b0;
      tick(30 * BIT);
      rx = 1'b1;
      tick(3 * BIT);
      checks++;
      if (brk_cnt - b0 != 1) begin
         errors++;
         $display("FAIL break_pulses: got %0d, expected 1", brk_cnt - b0);
      end
      checks++;
      if (beats.size() != 0) begin
         errors++;
         $display("FAIL break_no_output: got %0d beats, expected 0", beats.size());
      end
   endtask

   task automatic test_reset_mid;
      beats.delete();
      rx = 1'b0; tick(BIT);
      rx = 1'b1; tick(BIT);
      rx = 1'b0; tick(BIT / 2);
      areset = 1'b1;
      rx = 1'b1;
      tick(4);
      areset = 1'b0;
      tick(3 * BIT);
      checks++;
      if (beats.size() != 0 || tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_output: got %0d beats, expected 0", beats.size());
      end
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 2);
      expect_one("after_reset_81", {2'b00, 8'h81});
   endtask

`ifdef UART_RX_MULTI_FIFO_EN
   task automatic test_overrun;
      int o0;
      beats.delete();
      tready = 1'b0;
      o0 = ovr_cnt;
      for (int i = 0; i < 16; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1, 1);
      checks++;
      if (ovr_cnt != o0) begin
         errors++;
         $display("FAIL overrun_early: got %0d pulses, expected 0", ovr_cnt - o0);
      end
      send_frame(1'b0, 8'h10, 1'b0, 1'b0, 1'b1, 1);
      checks++;
      if (ovr_cnt - o0 != 1) begin
         errors++;
         $display("FAIL overrun_17th: got %0d pulses, expected 1", ovr_cnt - o0);
      end
      tready = 1'b1;
      tick(40);
      checks++;
      if (beats.size() != 16) begin
         errors++;
         $display("FAIL drain_count: got %0d, expected 16", beats.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (beats[i] !== {2'b00, 8'(i)}) begin
               errors++;
               $display("FAIL drain_%0d: got %h, expected %h", i, beats[i], {2'b00, 8'(i)});
            end
         end
      end
      beats.delete();
   endtask
`else
   task automatic test_overrun;
      int o0;
      beats.delete();
      tready = 1'b0;
      o0 = ovr_cnt;
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1);
      checks++;
      if (ovr_cnt != o0) begin
         errors++;
         $display("FAIL overrun_early: got %0d pulses, expected 0", ovr_cnt - o0);
      end
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1);
      checks++;
      if (ovr_cnt - o0 != 1) begin
         errors++;
         $display("FAIL overrun_2nd: got %0d pulses, expected 1", ovr_cnt - o0);
      end
      checks++;
      if (tvalid !== 1'b1 || {tuser, tdata} !== 10'h011) begin
         errors++;
         $display("FAIL hold_stable: got v=%b %h, expected v=1 011", tvalid, {tuser, tdata});
      end
      tready = 1'b1;
      tick(4);
      expect_one("drain_11", {2'b00, 8'h11});
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_glitch();
      test_back_to_back();
      test_break();
      test_reset_mid();
      test_overrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_multi.md
UART_RX_MULTI -- requirements
Module: uart_rx_multi

Interface
REQ-001 SHALL have parameter CLOCK, default 100_000_000, meaning aclk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning line bit rate; COUNT_SPEED = CLOCK/BAUD_RATE clocks per bit.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO entries, power of 2, >= 2.
REQ-007 SHALL have port aclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port areset, input, 1, meaning asynchronous active-high reset.
REQ-009 SHALL have port uart_rx, input, 1, meaning asynchronous serial line, idle high.
REQ-010 SHALL have port m_axis_tdata, output, DATA_BITS, meaning received word, LSB = first data bit.
REQ-011 SHALL have port m_axis_tuser, output, 2, meaning [1] parity error, [0] framing error for the word on tdata.
REQ-012 SHALL have ports m_axis_tvalid (output, 1) and m_axis_tready (input, 1), meaning AXI-Stream handshake.
REQ-013 SHALL have port overrun, output, 1, meaning one-cycle pulse when a completed word is dropped.
REQ-014 SHALL have port break_det, output, 1, meaning one-cycle pulse on break condition.

Function
REQ-015 SHALL pass uart_rx through a 2-flop synchroniser; all further references use the synchronised value.
REQ-016 SHALL take every bit value as the majority of samples at counts COUNT_SPEED/2-1, COUNT_SPEED/2, COUNT_SPEED/2+1 within the bit.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-018 IDLE -> START on synchronised line low; START -> IDLE if the start-bit majority is 1 (glitch, nothing output), else -> DATA.
REQ-019 DATA SHALL capture DATA_BITS bits LSB-first, then -> PARITY if PARITY != 0, else -> STOP.
REQ-020 PARITY SHALL flag error when the received bit differs from the even/odd parity computed over the data bits.
REQ-021 STOP SHALL check STOP_BITS stop bits; any low stop bit sets framing error.
REQ-022 SHALL return to IDLE immediately after the last stop-bit majority is resolved (mid-bit), so a start bit following a short stop is detected.
REQ-023 Break: all data bits 0, parity bit (if any) 0 and stop bit 0 -> pulse break_det, push nothing, -> BREAK_WAIT; BREAK_WAIT -> IDLE on line high.
REQ-024 Non-break frames SHALL be pushed with tuser flags even if errored; push occurs in the cycle the last stop-bit majority resolves.
REQ-025 m_axis_tvalid SHALL rise the cycle after a push into an empty buffer; transfer on tvalid && tready.
REQ-026 tdata/tuser SHALL be held stable while tvalid && !tready.
REQ-027 Push with buffer full and no pop that cycle -> new word dropped, overrun pulses 1 cycle; push and pop in the same full cycle -> both accepted, no overrun.
REQ-028 Words SHALL leave in arrival order.

Reset
REQ-029 areset SHALL asynchronously force state IDLE, all counters 0, buffer empty, tvalid 0, tdata 0, tuser 0, overrun 0, break_det 0, synchroniser flops 1.
REQ-030 Reset mid-frame SHALL discard the partial frame; reception resumes on the next falling edge after release.

Configuration
REQ-031 Macro UART_RX_MULTI_FIFO_EN defined: output buffer is a FIFO of FIFO_DEPTH entries.
REQ-032 Macro UART_RX_MULTI_FIFO_EN undefined: output buffer is a single register (depth 1), FIFO_DEPTH ignored, REQ-027 rules apply with depth 1.

Verification (CLOCK=100e6, BAUD=115200, COUNT_SPEED=868)
REQ-033 8N1 frame 0xA5, tready=1 -> one beat tdata=0xA5, tuser=00.
REQ-034 PARITY=1, data 0x03 with parity bit 1 -> tdata=0x03, tuser=10; parity bit 0 -> tuser=00.
REQ-035 Frame 0x55 with stop bit low -> tdata=0x55, tuser=01, no break_det.
REQ-036 400-clock low glitch on idle line -> no tvalid, FSM back in IDLE, next 0x3C received correctly.
REQ-037 FIFO_EN, FIFO_DEPTH=16, tready=0, 17 frames 0x00..0x10 -> overrun pulses once at 17th, drain yields 0x00..0x0F in order.
REQ-038 Line low 3 frame times -> exactly one break_det pulse, no tvalid; areset asserted mid-DATA -> tvalid stays 0, next frame 0x81 received intact.
